// File: rtl/receptor_codigo_if.sv
// Bus between the IE01/IE02 code sources and the code receiver.
// Carries the decision word, both candidate codes and every receiver output.
interface receptor_codigo_if #(
    parameter int CODE_W = 4
);
    logic [1:0]        dec;
    logic [CODE_W-1:0] cod_ie01;
    logic [CODE_W-1:0] cod_ie02;
    logic [CODE_W-1:0] codigo;
    logic              valido;
    logic              ack_ie01;
    logic              ack_ie02;
    logic              ocupado;
    logic [3:0]        descartes;

    modport master (
        output dec, cod_ie01, cod_ie02,
        input  codigo, valido, ack_ie01, ack_ie02, ocupado, descartes
    );

    modport slave (
        input  dec, cod_ie01, cod_ie02,
        output codigo, valido, ack_ie01, ack_ie02, ocupado, descartes
    );
endinterface

// File: rtl/receptor_codigo.sv
// Code receiver: captures a code from IE01 or IE02, presents it for HOLD_CYC
// cycles, acknowledges the source once, and counts requests refused while busy.
module receptor_codigo #(
    parameter int CODE_W   = 4,
    parameter int HOLD_CYC = 8
) (
    input logic              clk,
    input logic              rst,
    receptor_codigo_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SEGURA = 2'd1,
        LIBERA = 2'd2
    } estado_t;

    localparam logic [7:0] HOLD_INI = 8'(HOLD_CYC - 1);

    estado_t           estado;
    logic [7:0]        cnt;
    logic              fonte;
    logic              dec0_q;
    logic [CODE_W-1:0] codigo_q;
    logic              valido_q;
    logic              ack01_q;
    logic              ack02_q;
    logic              ocupado_q;
    logic [3:0]        descartes_q;

    logic [CODE_W-1:0] cod_sel;
    logic              descarta;

    // NOTE: every signal written here gets a value on all paths, so no latch is inferred.
    always_comb begin
        cod_sel  = bus.dec[1] ? bus.cod_ie02 : bus.cod_ie01;
        descarta = bus.dec[0] & ~dec0_q & ocupado_q;
    end

    // Outputs are registered, so the ack is scheduled one edge ahead of the
    // cycle in which the hold counter reads zero.
    // NOTE: non-blocking assignments keep every register updated from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= OCIOSO;
            cnt         <= '0;
            fonte       <= 1'b0;
            dec0_q      <= 1'b0;
            codigo_q    <= '0;
            valido_q    <= 1'b0;
            ack01_q     <= 1'b0;
            ack02_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            descartes_q <= '0;
        end else begin
            dec0_q  <= bus.dec[0];
            ack01_q <= 1'b0;
            ack02_q <= 1'b0;

            if (descarta && descartes_q != 4'hF)
                descartes_q <= descartes_q + 4'd1;

            case (estado)
                OCIOSO: begin
                    if (bus.dec[0]) begin
                        codigo_q  <= cod_sel;
                        fonte     <= bus.dec[1];
                        cnt       <= HOLD_INI;
                        valido_q  <= 1'b1;
                        ocupado_q <= 1'b1;
                        estado    <= SEGURA;
                        if (HOLD_CYC == 1) begin
                            ack02_q <= bus.dec[1];
                            ack01_q <= ~bus.dec[1];
                        end
                    end
                end
                SEGURA: begin
                    if (cnt == 8'd0) begin
                        valido_q <= 1'b0;
                        estado   <= LIBERA;
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            ack02_q <= fonte;
                            ack01_q <= ~fonte;
                        end
                    end
                end
                LIBERA: begin
                    if (!bus.dec[0]) begin
                        ocupado_q <= 1'b0;
                        estado    <= OCIOSO;
                    end
                end
                default: begin
                    valido_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado    <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.codigo    = codigo_q;
    assign bus.valido    = valido_q;
    assign bus.ack_ie01  = ack01_q;
    assign bus.ack_ie02  = ack02_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.descartes = descartes_q;

endmodule
